// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel edge-direction frame sequencer.
package sobel_pkg;

   // Frame sequencer states
   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StFlush = 2'd2
   } state_e;

   // One-hot edge direction codes produced by the datapath
   localparam logic [3:0] DIR_NONE    = 4'b0000;
   localparam logic [3:0] DIR_135_180 = 4'b0001;
   localparam logic [3:0] DIR_0_45    = 4'b0010;
   localparam logic [3:0] DIR_90_135  = 4'b0100;
   localparam logic [3:0] DIR_45_90   = 4'b1000;

   localparam int unsigned THR_W_DEF    = 11;
   localparam int unsigned PIPE_LAT_DEF = 6;
   localparam int unsigned STATS_W      = 20;

endpackage

// File: rtl/sobel_tag_pipe.sv
// Fixed-depth delay line carrying {valid, x, y} tags alongside the datapath.
module sobel_tag_pipe
   import sobel_pkg::*;
#(
   parameter int unsigned XW    = 10,
   parameter int unsigned DEPTH = PIPE_LAT_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [XW-1:0] in_x,
   input  logic [XW-1:0] in_y,
   output logic          out_valid,
   output logic [XW-1:0] out_x,
   output logic [XW-1:0] out_y
);

   logic [DEPTH-1:0] vld_q;
   logic [XW-1:0]    x_q [DEPTH];
   logic [XW-1:0]    y_q [DEPTH];

   // Shift every cycle; a cleared line holds only invalid tags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            vld_q[i] <= 1'b0;
            x_q[i]   <= '0;
            y_q[i]   <= '0;
         end
      end else begin
         vld_q[0] <= in_valid;
         x_q[0]   <= in_x;
         y_q[0]   <= in_y;
         for (int i = 1; i < DEPTH; i++) begin
            vld_q[i] <= vld_q[i-1];
            x_q[i]   <= x_q[i-1];
            y_q[i]   <= y_q[i-1];
         end
      end
   end

   assign out_valid = vld_q[DEPTH-1];
   assign out_x     = x_q[DEPTH-1];
   assign out_y     = y_q[DEPTH-1];

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for the Sobel edge-direction stage: window stepping, threshold
// register, coordinate tagging of datapath results and end-of-frame signalling.
// Optional per-frame edge statistics are enabled with SOBEL_EDGE_STATS_EN.
module sobel_frame_ctrl
   import sobel_pkg::*;
#(
   parameter int unsigned IMG_W    = 640,
   parameter int unsigned IMG_H    = 480,
   parameter int unsigned XW       = 10,
   parameter int unsigned PIPE_LAT = PIPE_LAT_DEF,
   parameter int unsigned THR_W    = THR_W_DEF,
   parameter int unsigned THR_INIT = 100
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             frame_start,
   input  logic             pix_valid,
   input  logic             cfg_valid,
   input  logic [THR_W-1:0] cfg_thresh,
   output logic             cfg_ready,
   output logic [THR_W-1:0] thresh,
   output logic             win_shift,
   input  logic [3:0]       dir_in,
   output logic             dout_valid,
   output logic [3:0]       dout_state,
   output logic [XW-1:0]    dout_x,
   output logic [XW-1:0]    dout_y,
   output logic             busy,
   output logic             frame_done
`ifdef SOBEL_EDGE_STATS_EN
   ,output logic [STATS_W-1:0] edge_count
`endif
);

   localparam int unsigned CW = $clog2(PIPE_LAT + 1);

   state_e        state_q, state_d;
   logic [XW-1:0] col_q, col_d, row_q, row_d;
   logic [CW-1:0] flush_q, flush_d;
   logic          frame_done_d;

   logic          tag_in_valid, tag_out_valid;
   logic [XW-1:0] tag_in_x, tag_in_y, tag_out_x, tag_out_y;

   // Next-state, raster counters and combinational handshakes
   always_comb begin
      state_d      = state_q;
      col_d        = col_q;
      row_d        = row_q;
      flush_d      = flush_q;
      frame_done_d = 1'b0;
      win_shift    = 1'b0;
      cfg_ready    = 1'b0;
      busy         = 1'b1;
      unique case (state_q)
         StIdle: begin
            cfg_ready = 1'b1;
            busy      = 1'b0;
            if (frame_start) begin
               state_d = StRun;
               col_d   = '0;
               row_d   = '0;
            end
         end
         StRun: begin
            win_shift = pix_valid;
            if (pix_valid) begin
               if (col_q == XW'(IMG_W - 1)) begin
                  col_d = '0;
                  if (row_q == XW'(IMG_H - 1)) begin
                     state_d = StFlush;
                     flush_d = CW'(PIPE_LAT);
                  end else begin
                     row_d = row_q + XW'(1);
                  end
               end else begin
                  col_d = col_q + XW'(1);
               end
            end
         end
         StFlush: begin
            if (flush_q == '0) begin
               state_d      = StIdle;
               frame_done_d = 1'b1;
            end else begin
               flush_d = flush_q - CW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Sequencer state, counters and threshold register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         col_q      <= '0;
         row_q      <= '0;
         flush_q    <= '0;
         frame_done <= 1'b0;
         thresh     <= THR_W'(THR_INIT);
      end else begin
         state_q    <= state_d;
         col_q      <= col_d;
         row_q      <= row_d;
         flush_q    <= flush_d;
         frame_done <= frame_done_d;
         if (cfg_valid && cfg_ready) begin
            thresh <= cfg_thresh;
         end
      end
   end

   // A pixel at col>=2, row>=2 closes the window centred one pixel up-left
   assign tag_in_valid = win_shift && (col_q >= XW'(2)) && (row_q >= XW'(2));
   assign tag_in_x     = col_q - XW'(1);
   assign tag_in_y     = row_q - XW'(1);

   sobel_tag_pipe #(
      .XW    (XW),
      .DEPTH (PIPE_LAT)
   ) u_tag_pipe (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (tag_in_valid),
      .in_x      (tag_in_x),
      .in_y      (tag_in_y),
      .out_valid (tag_out_valid),
      .out_x     (tag_out_x),
      .out_y     (tag_out_y)
   );

   // Pair the exiting tag with the datapath direction; coordinates hold between results
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout_valid <= 1'b0;
         dout_state <= DIR_NONE;
         dout_x     <= '0;
         dout_y     <= '0;
      end else if (tag_out_valid) begin
         dout_valid <= 1'b1;
         dout_state <= dir_in;
         dout_x     <= tag_out_x;
         dout_y     <= tag_out_y;
      end else begin
         dout_valid <= 1'b0;
         dout_state <= DIR_NONE;
      end
   end

`ifdef SOBEL_EDGE_STATS_EN
   logic [STATS_W-1:0] acc_q, acc_inc;

   // Saturating count of non-empty directions, including the result visible this cycle
   always_comb begin
      acc_inc = acc_q;
      if (dout_valid && (dout_state != DIR_NONE) && (acc_q != '1)) begin
         acc_inc = acc_q + STATS_W'(1);
      end
   end

   // Accumulate per frame; publish the final count together with frame_done
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q      <= '0;
         edge_count <= '0;
      end else begin
         if (frame_start && (state_q == StIdle)) begin
            acc_q <= '0;
         end else begin
            acc_q <= acc_inc;
         end
         if (frame_done_d) begin
            edge_count <= acc_inc;
         end
      end
   end
`endif

endmodule

// File: doc/sobel_frame_ctrl.md
# sobel_frame_ctrl

Frame sequencer for the Sobel edge-direction stage. It accepts a raster pixel stream and advances the 3x3 window feeding the direction datapath. It also owns the gradient threshold register and tags each datapath result with its image coordinates. Interior-pixel results are emitted with a valid strobe, followed by a per-frame completion pulse once the fixed-latency datapath has drained.

## Interface
- IMG_W, 640, pixels per line (min 3)
- IMG_H, 480, lines per frame (min 3)
- XW, 10, coordinate width (IMG_W, IMG_H ≤ 2^XW)
- PIPE_LAT, 6, cycles from window shift to datapath state output
- THR_W, 11, threshold width
- THR_INIT, 100, threshold value after reset
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- frame_start  in  1  one-cycle frame start strobe
- pix_valid  in  1  a new raster pixel is present this cycle
- cfg_valid  in  1  threshold write request
- cfg_thresh  in  THR_W  new threshold value
- cfg_ready  out  1  threshold write accepted this cycle
- thresh  out  THR_W  threshold driven to the datapath
- win_shift  out  1  advance window and line buffers
- dir_in  in  4  one-hot direction state from the datapath
- dout_valid  out  1  result valid
- dout_state  out  4  direction state for (dout_x, dout_y)
- dout_x, dout_y  out  XW  window-center coordinates
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse at end of frame

## Operation
- FSM states: IDLE, RUN, FLUSH.
- IDLE → RUN on frame_start. Column and row counters clear to 0.
- pix_valid outside RUN is ignored.
- In RUN, win_shift = pix_valid (combinational).
  - Each accepted pixel at (col, row) increments col.
  - col wraps at IMG_W-1 → 0 and row increments.
- An accepted pixel with col≥2 and row≥2 completes an interior window centered at (col-1, row-1). A tag {valid, x, y} for that window enters the tag delay line. Other pixels enter an invalid tag.
- Accepting the last pixel (IMG_W-1, IMG_H-1) moves RUN → FLUSH and loads a flush counter with PIPE_LAT.
- FLUSH → IDLE when the counter reaches 0. frame_done pulses in the first IDLE cycle.
- frame_start during RUN or FLUSH is ignored. The current frame always completes.
- The tag delay line shifts every cycle, regardless of pix_valid.
  - A valid tag exiting it registers dout_valid=1, dout_state=dir_in, and dout_x/dout_y.
  - An invalid tag registers dout_valid=0, dout_state=0, and holds dout_x/dout_y.
- Per frame, results = (IMG_W-2)·(IMG_H-2), emitted in raster order.
- cfg_ready = (state==IDLE). On cfg_valid && cfg_ready, thresh ← cfg_thresh.
  - frame_start and cfg_valid in the same IDLE cycle: both take effect; the new threshold applies to that frame.
- busy = (state≠IDLE).

## Timing
- Reset values:
  - state IDLE; counters 0; tags invalid.
  - thresh = THR_INIT, cfg_ready = 1.
  - win_shift, dout_valid, dout_state, dout_x, dout_y, busy, frame_done = 0.
- Reset mid-frame: all of the above apply immediately. No frame_done is produced, and in-flight tags are discarded.
- Latency for a pixel accepted at edge k:
  - dir_in is sampled at edge k+PIPE_LAT.
  - dout_* are visible in the cycle after edge k+PIPE_LAT.
- frame_done is asserted PIPE_LAT+1 cycles after the edge accepting the last pixel, for exactly one cycle, with busy=0.
- Back-to-back frames: frame_start is accepted in the same cycle frame_done is high.
- pix_valid gaps of any length are legal. Gaps only stretch the output spacing; pixel positions are unaffected.

## Configuration
- SOBEL_EDGE_STATS_EN defined:
  - Adds output edge_count (20 bits, reset 0).
  - An internal accumulator clears on frame start.
  - The accumulator increments on dout_valid with dout_state≠0, saturating at 2^20-1.
  - edge_count updates with the final count in the same cycle frame_done asserts, then holds until the next frame_done.
- Not defined: port and logic are absent, with no other change.

## Structure
- Shared package sobel_pkg:
  - FSM state enum.
  - Direction codes: DIR_NONE=4'b0000, DIR_135_180=4'b0001, DIR_0_45=4'b0010, DIR_90_135=4'b0100, DIR_45_90=4'b1000.
  - Default THR_W and PIPE_LAT.
- One sub-module, sobel_tag_pipe: a PIPE_LAT-deep shift register of {valid, x, y} with asynchronous clear.

## Test plan
- IMG_W=8, IMG_H=6, continuous pix_valid after frame_start:
  - 24 results; first at (1,1), last at (6,4).
  - frame_done exactly 7 cycles after the last accepted pixel.
- dir_in driven as a pattern keyed to the cycle; 4'b0010 at the exit of tag (3,2) → dout_state=4'b0010 with dout_x=3, dout_y=2. Invalid tags → dout_state=0.
- pix_valid toggling 1,0,0,1 → same 24 coordinates in the same order; cycle gaps preserved.
- cfg_valid with 11'd300 during RUN → cfg_ready=0 and thresh unchanged. Repeat in IDLE together with frame_start → thresh=300 from the next cycle.
- Reset asserted at row 3 → all outputs 0 and thresh=100. The next frame produces 24 results and one frame_done; frame_start during FLUSH is ignored.
- With SOBEL_EDGE_STATS_EN, 5 nonzero dir_in values on valid tags → edge_count=5 in the frame_done cycle.
